uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO, frames sent back-to-back while words are queued.
// Optional parity bit compiled in with `define UART_TX_PARITY_EN (even, or odd when PARITY_ODD=1).
module uart_tx_fifo #(
  parameter int OVERSAMPLING = 16,
  parameter int BDDIVIDER    = 27,
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          CLK_I,
  input  logic                          RST_NI,
  input  logic [DATA_WIDTH-1:0]         DATA_I,
  input  logic                          VALID_I,
  output logic                          READY_O,
  output logic                          TX_O,
  output logic                          TX_DONE_O,
  output logic                          BUSY_O,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL_O,
  output logic [2:0]                    state_dbg
);
  // Handshake: a word is taken on a rising edge where VALID_I and READY_O are both high;
  // VALID_I while READY_O is low is ignored and leaves the FIFO untouched.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (BDDIVIDER > 1) ? $clog2(BDDIVIDER) : 1;
  localparam int TW = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
  localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           level;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         baud_cnt;
  logic [TW-1:0]         tick_cnt;
  logic [3:0]            bit_idx;
  logic                  tx_q, done_q;
  logic                  push, pop, bit_end, last_stop;
`ifdef UART_TX_PARITY_EN
  logic                  par_bit;
`endif

  assign READY_O   = (level < DEPTH_L);
  assign push      = VALID_I && READY_O;
  assign bit_end   = (baud_cnt == BW'(BDDIVIDER - 1)) && (tick_cnt == TW'(OVERSAMPLING - 1));
  assign last_stop = (bit_idx == 4'(STOP_BITS - 1));
  // The head word leaves the FIFO either from idle or on the closing edge of the last stop bit.
  assign pop       = (level != '0) &&
                     ((state == S_IDLE) || ((state == S_STOP) && bit_end && last_stop));

  always_ff @(posedge CLK_I) begin
    if (push) mem[wr_ptr] <= DATA_I;
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state    <= S_IDLE;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      shreg    <= '0;
      baud_cnt <= '0;
      tick_cnt <= '0;
      bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state != S_IDLE) begin
        if (bit_end) begin
          baud_cnt <= '0;
          tick_cnt <= '0;
        end else if (baud_cnt == BW'(BDDIVIDER - 1)) begin
          baud_cnt <= '0;
          tick_cnt <= tick_cnt + 1'b1;
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
      case (state)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            state    <= S_START;
            tx_q     <= 1'b0;
            shreg    <= mem[rd_ptr];
            baud_cnt <= '0;
            tick_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= (^mem[rd_ptr]) ^ PARITY_ODD[0];
`endif
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            tx_q    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == 4'(DATA_WIDTH - 1)) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= S_PARITY;
              tx_q    <= par_bit;
`else
              state   <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state   <= S_STOP;
            tx_q    <= 1'b1;
            bit_idx <= '0;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              done_q <= 1'b1;
              // Next queued word starts on the same edge, so frames abut with no idle gap.
              if (pop) begin
                state    <= S_START;
                tx_q     <= 1'b0;
                shreg    <= mem[rd_ptr];
                baud_cnt <= '0;
                tick_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                par_bit  <= (^mem[rd_ptr]) ^ PARITY_ODD[0];
`endif
              end else begin
                state <= S_IDLE;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign TX_O      = tx_q;
  assign TX_DONE_O = done_q;
  assign BUSY_O    = (state != S_IDLE);
  assign LEVEL_O   = level;
  assign state_dbg = state;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based line model checked every cycle plus literal frame/timing pins.
module tb_uart_tx_fifo;
  localparam int BIT = 16 * 27;
`ifdef UART_TX_PARITY_EN
  localparam int NB8 = 11;
  localparam int NB7 = 11;
`else
  localparam int NB8 = 10;
  localparam int NB7 = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] din = '0;
  logic valid = 1'b0;
  logic ready, tx, done, busy;
  logic [2:0] level, st;
  logic [6:0] din7 = '0;
  logic valid7 = 1'b0;
  logic ready7, tx7, done7, busy7;
  logic [2:0] level7, st7;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo dut (
    .CLK_I(clk), .RST_NI(rst_n), .DATA_I(din), .VALID_I(valid), .READY_O(ready),
    .TX_O(tx), .TX_DONE_O(done), .BUSY_O(busy), .LEVEL_O(level), .state_dbg(st)
  );

  uart_tx_fifo #(.DATA_WIDTH(7), .STOP_BITS(2), .PARITY_ODD(1)) dut7 (
    .CLK_I(clk), .RST_NI(rst_n), .DATA_I(din7), .VALID_I(valid7), .READY_O(ready7),
    .TX_O(tx7), .TX_DONE_O(done7), .BUSY_O(busy7), .LEVEL_O(level7), .state_dbg(st7)
  );

  // Line model: queued words, plus the remaining bits of the frame on the line.
  logic [7:0] exp_q[$];
  bit         m_line[$];
  int         m_clk = 0;
  bit         m_busy = 0;
  bit         m_done = 0;

  always @(posedge clk or negedge rst_n) begin
    bit         do_push;
    logic [7:0] w;
    if (!rst_n) begin
      exp_q.delete();
      m_line.delete();
      m_clk  = 0;
      m_busy = 0;
      m_done = 0;
    end else begin
      do_push = valid && (exp_q.size() < 4);
      m_done  = 0;
      if (m_busy) begin
        m_clk++;
        if (m_clk == BIT) begin
          m_clk = 0;
          void'(m_line.pop_front());
          if (m_line.size() == 0) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
      if (!m_busy && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        m_line.push_back(1'b0);
        for (int i = 0; i < 8; i++) m_line.push_back(w[i]);
`ifdef UART_TX_PARITY_EN
        m_line.push_back(^w);
`endif
        m_line.push_back(1'b1);
        m_busy = 1;
        m_clk  = 0;
      end
      if (do_push) exp_q.push_back(din);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic exp_tx;
    exp_tx = m_busy ? m_line[0] : 1'b1;
    check("model tx", {31'd0, tx}, {31'd0, exp_tx});
    check("model busy", {31'd0, busy}, {31'd0, m_busy});
    check("model done", {31'd0, done}, {31'd0, m_done});
    check("model level", {29'd0, level}, exp_q.size());
    check("model ready", {31'd0, ready}, {31'd0, exp_q.size() < 4});
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_done(input bit sel7, output int when);
    when = -1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ((sel7 ? done7 : done) === 1'b1) begin
        when = cyc;
        break;
      end
    end
  endtask

  task automatic push_word(input logic [7:0] d, output int k);
    din   = d;
    valid = 1'b1;
    @(negedge clk);
    k     = cyc;
    valid = 1'b0;
  endtask

  initial begin
    int k, k2, t, prev;
    logic [10:0] fb;
    logic [7:0] burst [6];
    burst[0] = 8'h55; burst[1] = 8'h0F; burst[2] = 8'hFF;
    burst[3] = 8'h00; burst[4] = 8'h81; burst[5] = 8'h3C;

    // Reset with no clock edge yet
    #1 rst_n = 1'b0;
    #1;
    check("rst tx", {31'd0, tx}, 1);
    check("rst ready", {31'd0, ready}, 1);
    check("rst busy", {31'd0, busy}, 0);
    check("rst level", {29'd0, level}, 0);
    check("rst done", {31'd0, done}, 0);
    check("rst state", {29'd0, st}, 0);
    check("rst tx7", {31'd0, tx7}, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word 0xA5
`ifdef UART_TX_PARITY_EN
    fb = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    fb = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
    push_word(8'hA5, k);
    for (int b = 0; b < NB8; b++) begin
      wait_until(k + 1 + b * BIT + BIT / 2);
      check("a5 frame bit", {31'd0, tx}, {31'd0, fb[b]});
    end
    wait_done(1'b0, t);
    check("a5 done time", t, k + 1 + NB8 * BIT);
    repeat (5) @(negedge clk);

    // FIFO full and back-to-back frames
    for (int i = 0; i < 6; i++) begin
      din   = burst[i];
      valid = 1'b1;
      @(negedge clk);
      if (i == 0) k = cyc;
      if (i == 4) begin
        check("full level", {29'd0, level}, 4);
        check("full ready", {31'd0, ready}, 0);
      end
    end
    valid = 1'b0;
    prev = k + 1 - NB8 * BIT + NB8 * BIT;
    wait_done(1'b0, t);
    check("b2b first done", t, k + 1 + NB8 * BIT);
    prev = t;
    for (int f = 1; f < 5; f++) begin
      wait_done(1'b0, t);
      check("b2b spacing", t - prev, NB8 * BIT);
      prev = t;
    end
    repeat (10) @(negedge clk);
    check("b2b drained busy", {31'd0, busy}, 0);

    // Random traffic
    for (int i = 0; i < 3; i++) begin
      din   = 8'($urandom);
      valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      din   = 8'($urandom);
      valid = ($urandom_range(0, 799) == 0);
      @(negedge clk);
    end
    valid = 1'b0;
    t = 0;
    while ((m_busy || exp_q.size() > 0) && t < 40000) begin
      @(negedge clk);
      t++;
    end
    check("random drain", {31'd0, t < 40000}, 1);
    repeat (5) @(negedge clk);

    // Abort mid-frame with a second word queued
    push_word(8'hA5, k);
    push_word(8'h33, k2);
    wait_until(k + 1 + 4 * BIT + 100);
    #2 rst_n = 1'b0;
    #1;
    check("abort tx", {31'd0, tx}, 1);
    check("abort done", {31'd0, done}, 0);
    check("abort busy", {31'd0, busy}, 0);
    check("abort level", {29'd0, level}, 0);
    check("abort ready", {31'd0, ready}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    check("post abort level", {29'd0, level}, 0);
    check("post abort tx", {31'd0, tx}, 1);

    // 7 data bits, 2 stop bits, odd parity when compiled in
`ifdef UART_TX_PARITY_EN
    fb = {1'b1, 1'b1, 1'b1, 7'h41, 1'b0};
`else
    fb = {1'b0, 1'b1, 1'b1, 7'h41, 1'b0};
`endif
    din7   = 7'h41;
    valid7 = 1'b1;
    @(negedge clk);
    k      = cyc;
    valid7 = 1'b0;
    for (int b = 0; b < NB7; b++) begin
      wait_until(k + 1 + b * BIT + BIT / 2);
      check("w7 frame bit", {31'd0, tx7}, {31'd0, fb[b]});
    end
    wait_done(1'b1, t);
    check("w7 done time", t, k + 1 + NB7 * BIT);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
